// File: rtl/flex_counter_sync.sv
// Synchronous up-counter that wraps from a runtime-programmable rollover value to 1,
// with a synchronous clear and a registered flag marking count == rollover_val.
module flex_counter_sync #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;
    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    flag;

    // Wrap goes to 1, not 0; otherwise a plain modulo-2^N increment, which also
    // carries a count that overshot a lowered rollover value back round through 0.
    always_comb begin
        next_count = count + NUM_CNT_BITS'(1);
        if (count == rollover_val) begin
            next_count = NUM_CNT_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            flag  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            flag  <= 1'b0;
        end else if (count_enable) begin
            count <= next_count;
            flag  <= (next_count == rollover_val);
        end else begin
            count <= count;
            flag  <= (count == rollover_val);
        end
    end

    assign count_out     = count;
    assign rollover_flag = flag;

endmodule

// File: tb/tb_flex_counter_sync.sv
// Directed self-checking bench for flex_counter_sync (NUM_CNT_BITS = 4):
// inputs change on the falling edge, outputs are checked on the next falling edge.
module tb_flex_counter_sync;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         clear;
    logic         count_enable;
    logic [N-1:0] rollover_val;
    logic [N-1:0] count_out;
    logic         rollover_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] chg_seq [15] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
                                   4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd1};

    flex_counter_sync #(.NUM_CNT_BITS(N)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [N-1:0] exp_count, input logic exp_flag);
        n_checks++;
        assert (count_out === exp_count && rollover_flag === exp_flag)
        else begin
            n_fail++;
            $error("FAIL %s: observed count=%0d flag=%b, expected count=%0d flag=%b",
                   tag, count_out, rollover_flag, exp_count, exp_flag);
        end
    endtask

    // Drive one edge's inputs at the falling edge, then wait for the next falling edge.
    task automatic tick(input logic en, input logic clr, input logic rst);
        count_enable = en;
        clear        = clr;
        RST          = rst;
        @(negedge CLK);
    endtask

    initial begin
        RST          = 1'b1;
        clear        = 1'b0;
        count_enable = 1'b0;
        rollover_val = 4'd3;

        // Reset held two cycles, then released with enable low
        @(negedge CLK);
        check("reset_cyc1", 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("reset_cyc2", 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("post_reset_idle", 4'd0, 1'b0);

        // Non-power-of-two rollover R=3
        tick(1'b1, 1'b0, 1'b0);
        check("r3_c1", 4'd1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("r3_c2", 4'd2, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("r3_c3", 4'd3, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("r3_wrap", 4'd1, 1'b0);

        // Continuous counting R=2
        tick(1'b0, 1'b1, 1'b0);
        check("clear_before_r2", 4'd0, 1'b0);
        rollover_val = 4'd2;
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("r2_cont_%0d", i), (i % 2 == 0) ? 4'd1 : 4'd2, (i % 2 == 1));
        end

        // Discontinuous counting R=10, enable toggling
        tick(1'b0, 1'b1, 1'b0);
        rollover_val = 4'd10;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0), 1'b0, 1'b0);
            check($sformatf("r10_toggle_%0d", i), 4'(i / 2 + 1), 1'b0);
        end

        // Clear wins over enable
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        check("pre_clear_count4", 4'd4, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("clear_and_enable", 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("after_clear", 4'd1, 1'b0);

        // Reset mid-count with enable high
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("reset_mid_count", 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("after_reset", 4'd1, 1'b0);

        // Rollover value change: count to 5 with R=5, then lower R to 3
        tick(1'b0, 1'b1, 1'b0);
        rollover_val = 4'd5;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        check("r5_at5", 4'd5, 1'b1);
        rollover_val = 4'd3;
        tick(1'b0, 1'b0, 1'b0);
        check("hold_flag_drops", 4'd5, 1'b0);
        rollover_val = 4'd5;
        tick(1'b0, 1'b0, 1'b0);
        check("hold_flag_tracks", 4'd5, 1'b1);
        rollover_val = 4'd3;
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("r_change_%0d", i), chg_seq[i], (i == 13));
        end

        // R=1: stays at 1 with flag high
        tick(1'b0, 1'b1, 1'b0);
        rollover_val = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("r1_%0d", i), 4'd1, 1'b1);
        end

        // R=0: 1..15, then 0 with flag, then 1
        tick(1'b0, 1'b1, 1'b0);
        rollover_val = 4'd0;
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("r0_%0d", i), 4'(i), 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        check("r0_zero", 4'd0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("r0_wrap", 4'd1, 1'b0);

        // R=15: full range, wraps 15 -> 1
        tick(1'b0, 1'b1, 1'b0);
        rollover_val = 4'd15;
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 1'b0);
        check("r15_top", 4'd15, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("r15_wrap", 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_counter_sync.md
# flex_counter_sync

Parameterizable synchronous up-counter with a runtime-programmable rollover value, a synchronous clear and a registered rollover flag. It is a generic building block for timers, bit/byte counters and baud or sample dividers inside larger controllers. It wraps from `rollover_val` to 1, not 0.

## Interface
Parameters:
- `NUM_CNT_BITS`, default 4: width of the counter and of `rollover_val`.

Ports:
- `CLK`, input, 1 bit: single clock; all state updates on the rising edge.
- `RST`, input, 1 bit: reset, synchronous and active-high.
- `clear`, input, 1 bit: synchronous clear of count and flag.
- `count_enable`, input, 1 bit: advance the count by one on this edge.
- `rollover_val`, input, `NUM_CNT_BITS` bits: value at which the count wraps; may change at any time.
- `count_out`, output, `NUM_CNT_BITS` bits: current count, registered.
- `rollover_flag`, output, 1 bit: high exactly while `count_out == rollover_val`, registered.

## Operation
- State:
  - `count` register drives `count_out`.
  - `flag` register drives `rollover_flag`.
- Priority at each rising `CLK` edge is RST > clear > count_enable > hold.
- RST=1: count←0, flag←0.
- clear=1 (RST=0): count←0, flag←0, regardless of `count_enable`.
- count_enable=1 (RST=0, clear=0):
  - next = 1 if count == rollover_val, else count+1 modulo 2^NUM_CNT_BITS.
  - count←next.
  - flag←(next == rollover_val).
- Otherwise count holds, and flag←(count == rollover_val), so the flag tracks a live change of `rollover_val` within one cycle.
- Resulting sequence with rollover_val=R and enable held: 1, 2, …, R, 1, 2, …; flag is high on every cycle the count equals R.
- Width rules:
  - Arithmetic is unsigned at `NUM_CNT_BITS`.
  - No output other than `count_out` and `rollover_flag`.
  - No carry output.
- Boundary cases:
  - rollover_val lowered below the current count: counting continues upward, wraps 2^N−1→0, then 0 increments to 1 (or wraps to 1 if R=0), and the normal cycle resumes once count reaches R.
  - rollover_val=0: the count leaves 0 to 1 and runs 1…2^N−1, then 0 (flag high), then 1 again.
  - rollover_val=1: count stays at 1 with flag high continuously while enabled.
  - rollover_val=2^N−1: full-range counter 1…2^N−1.
  - clear and count_enable asserted together: clear wins; the result is 0 with flag 0.
  - Reset or clear mid-count: the result is 0 on that edge, and the next enabled edge gives 1.

## Timing
- Both outputs come straight from flip-flops; there is no combinational path from inputs to outputs.
- Latency is one cycle: an input sampled at edge k is visible after edge k, so benches sample at the following falling edge.
- The flag is asserted in the same cycle `count_out` first shows the rollover value, and deasserts on the edge that wraps to 1.
- After reset release, `count_out` stays 0 until the first edge with count_enable=1.
- Enable may toggle every cycle; each enabled edge advances by exactly one.

## Test plan
- Reset: hold RST=1 for 2 cycles with enable low -> count_out=0 and flag=0, both during reset and after release.
- Non-power-of-two rollover: R=3, enable held for 3 cycles after reset -> count 1, 2, 3; flag=1 at 3, then 1 with flag=0 on the next edge.
- Continuous counting: R=2, enable held for 15 cycles -> count alternates 1, 2, 1, 2…, flag=1 exactly on cycles where count=2.
- Discontinuous counting: R=10, enable toggled every cycle -> count advances only on enabled edges (1, 1, 2, 2, 3…), flag stays 0.
- Clear priority: R=10, count to 4, then assert clear and enable together for 1 cycle -> count_out=0, flag=0; the next enabled edge gives 1.
- Rollover value change: count at 5, R set 5→3 -> flag drops after the next edge; count continues 6…15, 0, 1, 2, 3 (flag=1), 1.
